// File: rtl/dm_store_buffer_pkg.sv
// Shared definitions for the posted-store buffer.
//   - DMType encodings of the data-memory access size
//   - sb_entry_t: one buffered store (address, right-aligned data, type)
//   - dm_span(): number of bytes an access of a given DMType touches
package dm_store_buffer_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int TYPE_W = 3;

  localparam logic [TYPE_W-1:0] DM_WORD              = 3'b000;
  localparam logic [TYPE_W-1:0] DM_HALFWORD          = 3'b001;
  localparam logic [TYPE_W-1:0] DM_HALFWORD_UNSIGNED = 3'b010;
  localparam logic [TYPE_W-1:0] DM_BYTE              = 3'b011;
  localparam logic [TYPE_W-1:0] DM_BYTE_UNSIGNED     = 3'b100;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TYPE_W-1:0] dtype;
  } sb_entry_t;

  // Unused encodings touch no bytes, so they never overlap anything and
  // the memory writes nothing for them.
  function automatic logic [2:0] dm_span(input logic [TYPE_W-1:0] t);
    logic [2:0] s;
    case (t)
      DM_WORD:                           s = 3'd4;
      DM_HALFWORD, DM_HALFWORD_UNSIGNED: s = 3'd2;
      DM_BYTE, DM_BYTE_UNSIGNED:         s = 3'd1;
      default:                           s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dm_store_buffer_sb_overlap.sv
// sb_overlap: byte-range intersection test between two (addr, type) pairs.
//   en             - gate (entry valid); hit is 0 when low
//   a_addr/a_type  - first access (buffered store)
//   b_addr/b_type  - second access (load)
//   hit            - the two byte ranges share at least one byte
module sb_overlap
  import dm_store_buffer_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [TYPE_W-1:0] a_type,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [TYPE_W-1:0] b_type,
  output logic              hit
);

  logic [2:0]      a_span;
  logic [2:0]      b_span;
  logic [ADDR_W:0] a_lo;
  logic [ADDR_W:0] a_hi;
  logic [ADDR_W:0] b_lo;
  logic [ADDR_W:0] b_hi;

  // One extra address bit keeps the end of a range near 0x1FF from
  // wrapping back to the bottom of the address space.
  always_comb begin
    a_span = dm_span(a_type);
    b_span = dm_span(b_type);
    a_lo   = {1'b0, a_addr};
    b_lo   = {1'b0, b_addr};
    a_hi   = a_lo + {7'd0, a_span};
    b_hi   = b_lo + {7'd0, b_span};
    hit    = en && (a_span != 3'd0) && (b_span != 3'd0) &&
             (a_lo < b_hi) && (b_lo < a_hi);
  end

endmodule

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-store FIFO in front of a single-port data memory.
// Stores are queued and drained in order on cycles where the port is not
// carrying a load; a load overlapping any pending store is stalled while
// the buffer drains.
//   clk, rst                     - clock, synchronous active-high reset
//   st_valid/st_ready            - store handshake; st_addr/st_data/st_type
//   ld_req, ld_addr, ld_type     - load presented this cycle
//   ld_stall                     - load must be re-presented next cycle
//   dm_wr/dm_addr/dm_din/dm_type - data-memory port
//   empty, count                 - buffer occupancy
module dm_store_buffer
  import dm_store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic [TYPE_W-1:0]        st_type,
  input  logic                     ld_req,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [TYPE_W-1:0]        ld_type,
  output logic                     ld_stall,
  output logic                     dm_wr,
  output logic [ADDR_W-1:0]        dm_addr,
  output logic [DATA_W-1:0]        dm_din,
  output logic [TYPE_W-1:0]        dm_type,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        mem_q [DEPTH];
  sb_entry_t        mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_hit;
  logic             hazard;
  logic             buf_empty;
  logic             enq;
  logic             deq;
  sb_entry_t        head;

  assign head      = mem_q[rd_ptr_q];
  assign buf_empty = (count_q == '0);
  assign hazard    = |ent_hit;

  // An entry is live when its distance from the read pointer (modulo
  // DEPTH) is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PW-1:0] offs;
    assign offs          = PW'(gi) - rd_ptr_q;
    assign ent_valid[gi] = ({1'b0, offs} < count_q);

    sb_overlap u_overlap (
      .en     (ent_valid[gi]),
      .a_addr (mem_q[gi].addr),
      .a_type (mem_q[gi].dtype),
      .b_addr (ld_addr),
      .b_type (ld_type),
      .hit    (ent_hit[gi])
    );
  end

  assign st_ready = !rst && (count_q != CW'(DEPTH));
  assign empty    = rst || buf_empty;
  assign count    = rst ? '0 : count_q;
  assign dm_din   = (!rst && !buf_empty) ? head.data : '0;

  // Port arbitration: a clean load owns the port; otherwise the head
  // entry drains (a hazard implies the buffer is non-empty).
  always_comb begin
    dm_wr    = 1'b0;
    ld_stall = 1'b0;
    dm_addr  = '0;
    dm_type  = '0;
    if (!rst) begin
      if (ld_req && !hazard) begin
        dm_addr = ld_addr;
        dm_type = ld_type;
      end else if (ld_req || !buf_empty) begin
        dm_wr    = 1'b1;
        ld_stall = ld_req;
        dm_addr  = head.addr;
        dm_type  = head.dtype;
      end
    end
  end

  assign enq = st_valid && st_ready;
  assign deq = dm_wr;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = '{addr: st_addr, data: st_data, dtype: st_type};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: liveness comes from the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;
  import dm_store_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_type;
  logic        ld_req;
  logic [8:0]  ld_addr;
  logic [2:0]  ld_type;
  logic        ld_stall;
  logic        dm_wr;
  logic [8:0]  dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  dm_type;
  logic        empty;
  logic [2:0]  count;

  dm_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_type(st_type),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_type(ld_type), .ld_stall(ld_stall),
    .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_din(dm_din), .dm_type(dm_type),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] mem_t [512];
  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [2:0]  typ;
  } ent_t;

  mem_t dm_mem;    // the data memory, written by the DUT's port
  mem_t arch_mem;  // program-order memory: every accepted store applied
  mem_t comm_mem;  // stores that have been drained
  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_stall = 1'b0;

  function automatic int bspan(input logic [2:0] t);
    case (t)
      3'd0:       return 4;
      3'd1, 3'd2: return 2;
      3'd3, 3'd4: return 1;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] rd_bytes(input mem_t m, input int a, input int s);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < s; k++)
      if (a + k < 512) r[8*k +: 8] = m[a+k];
    return r;
  endfunction

  function automatic bit overlaps(input int a, input int sa, input int b, input int sb);
    if (sa == 0 || sb == 0) return 1'b0;
    return (a < b + sb) && (b < a + sa);
  endfunction

  // Behavioural single-port memory.
  always @(posedge clk) begin
    if (dm_wr)
      for (int k = 0; k < bspan(dm_type); k++)
        if (int'(dm_addr) + k < 512) dm_mem[int'(dm_addr) + k] <= dm_din[8*k +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference for the current inputs,
  // then apply what the coming clock edge does to the reference.
  task automatic model_step();
    int  n;
    bit  hz;
    bit  exp_wr;
    n  = q.size();
    hz = 1'b0;
    if (rst) begin
      chk("rst_st_ready", st_ready, 0);
      chk("rst_dm_wr", dm_wr, 0);
      chk("rst_ld_stall", ld_stall, 0);
      chk("rst_empty", empty, 1);
      chk("rst_count", count, 0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_dm_din", dm_din, 0);
      chk("rst_dm_type", dm_type, 0);
      q.delete();
      arch_mem   = comm_mem;
      last_stall = 1'b0;
      return;
    end
    if (ld_req)
      foreach (q[i])
        if (overlaps(q[i].addr, bspan(q[i].typ), ld_addr, bspan(ld_type))) hz = 1'b1;
    exp_wr = ld_req ? hz : (n > 0);
    chk("st_ready", st_ready, (n != DEPTH));
    chk("count", count, n);
    chk("empty", empty, (n == 0));
    chk("ld_stall", ld_stall, (ld_req && hz));
    chk("dm_wr", dm_wr, exp_wr);
    chk("dm_din", dm_din, (n > 0) ? q[0].data : 32'h0);
    if (exp_wr) begin
      chk("drain_addr", dm_addr, q[0].addr);
      chk("drain_type", dm_type, q[0].typ);
    end else if (ld_req) begin
      chk("load_addr", dm_addr, ld_addr);
      chk("load_type", dm_type, ld_type);
      chk("load_data", rd_bytes(dm_mem, int'(dm_addr), bspan(dm_type)),
          rd_bytes(arch_mem, int'(ld_addr), bspan(ld_type)));
    end else begin
      chk("idle_addr", dm_addr, 0);
      chk("idle_type", dm_type, 0);
    end
    last_stall = ld_req && hz;
    if (exp_wr) begin
      for (int k = 0; k < bspan(q[0].typ); k++)
        if (int'(q[0].addr) + k < 512) comm_mem[int'(q[0].addr) + k] = q[0].data[8*k +: 8];
      void'(q.pop_front());
    end
    if (st_valid && n != DEPTH) begin
      q.push_back('{addr: st_addr, data: st_data, typ: st_type});
      for (int k = 0; k < bspan(st_type); k++)
        if (int'(st_addr) + k < 512) arch_mem[int'(st_addr) + k] = st_data[8*k +: 8];
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic set_st(input logic v, input logic [8:0] a, input logic [31:0] d, input logic [2:0] t);
    st_valid = v; st_addr = a; st_data = d; st_type = t;
  endtask

  task automatic set_ld(input logic v, input logic [8:0] a, input logic [2:0] t);
    ld_req = v; ld_addr = a; ld_type = t;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      dm_mem[i] = 8'h0; arch_mem[i] = 8'h0; comm_mem[i] = 8'h0;
    end
    rst = 1'b1;
    set_st(0, 0, 0, 0);
    set_ld(0, 0, 0);
    @(posedge clk); #1;

    // Shared span helper agrees with the access-size table.
    for (int t = 0; t < 8; t++) begin
      logic [2:0] tt;
      tt = 3'(t);
      chk("pkg_span", 32'(dm_span(tt)), bspan(tt));
    end

    // Reset state.
    sample();
    chk("reset_ready", st_ready, 0);
    chk("reset_count", count, 0);
    advance();
    rst = 1'b0;

    // Basic drain.
    set_st(1, 9'h010, 32'h12345678, DM_WORD);
    cyc();
    set_st(0, 0, 0, 0);
    sample();
    chk("basic_wr", dm_wr, 1);
    chk("basic_addr", dm_addr, 9'h010);
    advance();
    sample();
    chk("basic_empty", empty, 1);
    advance();
    set_ld(1, 9'h010, DM_WORD);
    sample();
    chk("basic_readback", rd_bytes(dm_mem, int'(dm_addr), 4), 32'h12345678);
    advance();

    // Full: four stores while an unrelated load holds the port.
    set_ld(1, 9'h100, DM_WORD);
    for (int i = 0; i < 4; i++) begin
      set_st(1, 9'(9'h080 + 4*i), 32'hA0000000 + i, DM_WORD);
      cyc();
    end
    set_st(1, 9'h0A0, 32'hDEADBEEF, DM_WORD);
    sample();
    chk("full_count", count, 4);
    chk("full_ready", st_ready, 0);
    advance();
    set_st(0, 0, 0, 0);
    set_ld(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("full_drain_wr", dm_wr, 1);
      chk("full_drain_addr", dm_addr, 9'(9'h080 + 4*i));
      advance();
    end
    sample();
    chk("full_empty", empty, 1);
    advance();

    // Hazard on partial overlap.
    set_st(1, 9'h023, 32'h000000AB, DM_BYTE);
    cyc();
    set_st(0, 0, 0, 0);
    set_ld(1, 9'h020, DM_WORD);
    sample();
    chk("hz_stall", ld_stall, 1);
    chk("hz_drain_addr", dm_addr, 9'h023);
    advance();
    sample();
    chk("hz_release", ld_stall, 0);
    chk("hz_load_addr", dm_addr, 9'h020);
    begin
      logic [31:0] w;
      w = rd_bytes(dm_mem, int'(dm_addr), 4);
      chk("hz_byte3", w[31:24], 8'hAB);
    end
    advance();

    // No hazard on an adjacent range.
    set_ld(1, 9'h100, DM_WORD);
    set_st(1, 9'h040, 32'h0000BEEF, DM_HALFWORD);
    cyc();
    set_st(0, 0, 0, 0);
    set_ld(1, 9'h042, DM_BYTE);
    sample();
    chk("adj_stall", ld_stall, 0);
    chk("adj_count", count, 1);
    advance();
    set_ld(0, 0, 0);
    cyc();

    // Enqueue and drain in the same cycle.
    set_ld(1, 9'h100, DM_WORD);
    set_st(1, 9'h060, 32'h11111111, DM_WORD); cyc();
    set_st(1, 9'h064, 32'h22222222, DM_WORD); cyc();
    set_ld(0, 0, 0);
    set_st(1, 9'h068, 32'h33333333, DM_WORD);
    sample();
    chk("ed_count_before", count, 2);
    chk("ed_drain_addr0", dm_addr, 9'h060);
    advance();
    set_st(0, 0, 0, 0);
    sample();
    chk("ed_count_after", count, 2);
    chk("ed_drain_addr1", dm_addr, 9'h064);
    advance();
    sample();
    chk("ed_drain_addr2", dm_addr, 9'h068);
    advance();

    // Reset with three pending entries.
    set_ld(1, 9'h100, DM_WORD);
    set_st(1, 9'h0C0, 32'h55555555, DM_WORD); cyc();
    set_st(1, 9'h0C4, 32'h66666666, DM_WORD); cyc();
    set_st(1, 9'h0C8, 32'h77777777, DM_WORD); cyc();
    set_st(0, 0, 0, 0);
    set_ld(0, 0, 0);
    rst = 1'b1;
    sample();
    chk("rmd_wr", dm_wr, 0);
    advance();
    rst = 1'b0;
    sample();
    chk("rmd_count", count, 0);
    chk("rmd_empty", empty, 1);
    advance();
    set_ld(1, 9'h0C0, DM_WORD);
    sample();
    chk("rmd_untouched", rd_bytes(dm_mem, int'(dm_addr), 4), 32'h0);
    advance();

    // Top of address space: no wrap to 0; span-0 entries never overlap.
    set_ld(1, 9'h100, DM_WORD);
    set_st(1, 9'h1FF, 32'hCAFEF00D, DM_WORD); cyc();
    set_st(1, 9'h000, 32'hFFFFFFFF, 3'b101); cyc();
    set_st(0, 0, 0, 0);
    set_ld(1, 9'h000, DM_BYTE);
    sample();
    chk("wrap_no_stall", ld_stall, 0);
    advance();
    set_ld(1, 9'h1FC, DM_WORD);
    sample();
    chk("top_stall", ld_stall, 1);
    advance();
    set_ld(0, 0, 0);
    cyc(); cyc();

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!last_stall) begin
        logic [8:0] a;
        a = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(9'h1F8, 9'h1FF))
                                        : 9'($urandom_range(0, 9'h03F));
        set_ld($urandom_range(0, 99) < 40, a, 3'($urandom_range(0, 7)));
      end
      begin
        logic [8:0] a;
        a = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(9'h1F8, 9'h1FF))
                                        : 9'($urandom_range(0, 9'h03F));
        if (ld_req && $urandom_range(0, 7) != 0)
          set_st(0, 0, 0, 0);
        else
          set_st($urandom_range(0, 1) == 1, a, $urandom, 3'($urandom_range(0, 7)));
      end
      cyc();
    end

    rst = 1'b0;
    set_st(0, 0, 0, 0);
    set_ld(0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) cyc();
    sample();
    chk("final_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
